// File: rtl/pwm_regs_pkg.sv
// Register map and shared types for the PWM/output-enable register bank.
// The SPI decoder, the preset loader and the PWM block all use this package.
package pwm_regs_pkg;

  localparam int ADDR_W_DEF   = 7;
  localparam int DATA_W_DEF   = 8;
  localparam int NUM_REGS_DEF = 5;

  localparam int ADDR_EN_OUT_LO = 0;
  localparam int ADDR_EN_OUT_HI = 1;
  localparam int ADDR_EN_PWM_LO = 2;
  localparam int ADDR_EN_PWM_HI = 3;
  localparam int ADDR_DUTY      = 4;

  // Round-robin pointer: names the requester that wins the next tie.
  typedef enum logic {
    PTR_A = 1'b0,
    PTR_B = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: pure combinational one-hot grant from the
// request vector and the current tie-break pointer.
module rr_arb2
  import pwm_regs_pkg::*;
(
  input  logic [1:0] valid_i,   // [0] = port A, [1] = port B
  input  rr_ptr_e    ptr_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = valid_i[0] & (~valid_i[1] | (ptr_i == PTR_A));
    grant_o[1] = valid_i[1] & (~valid_i[0] | (ptr_i == PTR_B));
  end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Arbitrates two register-write requesters into a shadow bank and commits
// shadow to the active bank immediately or on a PWM period boundary.
module pwm_cfg_arbiter
  import pwm_regs_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  input  logic                sync_mode,
  input  logic                period_end,
  output logic [2*DATA_W-1:0] en_out,
  output logic [2*DATA_W-1:0] en_pwm,
  output logic [DATA_W-1:0]   duty,
  output logic                pending,
  output logic                bad_addr
);

  // Handshake: a requester holds valid/addr/data stable until it sees ready
  // high in the same cycle; the transfer happens on the edge where valid &
  // ready are both 1. Ready is combinational and never asserted in reset.

  rr_ptr_e            ptr_q, ptr_d;
  logic [1:0]         grant;
  logic               wr_en;
  logic               wr_hit;
  logic [ADDR_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  wr_data;
  logic               pending_q, pending_d;
  logic               bad_addr_q, bad_addr_d;
  logic [DATA_W-1:0]  shadow_q [NUM_REGS];
  logic [DATA_W-1:0]  shadow_d [NUM_REGS];
  logic [DATA_W-1:0]  active_q [NUM_REGS];
  logic [DATA_W-1:0]  active_d [NUM_REGS];

  rr_arb2 u_arb (
    .valid_i ({b_valid, a_valid}),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  assign a_ready = grant[0] & ~rst;
  assign b_ready = grant[1] & ~rst;
  assign wr_en   = a_ready | b_ready;
  assign wr_addr = a_ready ? a_addr : b_addr;
  assign wr_data = a_ready ? a_data : b_data;
  assign wr_hit  = wr_en && (wr_addr < ADDR_W'(NUM_REGS));

  always_comb begin
    ptr_d      = ptr_q;
    bad_addr_d = wr_en & ~wr_hit;
    pending_d  = pending_q;
    shadow_d   = shadow_q;
    active_d   = active_q;

    if (a_ready)      ptr_d = PTR_B;
    else if (b_ready) ptr_d = PTR_A;

    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_hit && (wr_addr == ADDR_W'(r))) shadow_d[r] = wr_data;
    end

    if (!sync_mode) begin
      // Leaving sync mode with uncommitted writes flushes the whole shadow.
      if (pending_q) active_d = shadow_q;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit && (wr_addr == ADDR_W'(r))) active_d[r] = wr_data;
      end
      pending_d = 1'b0;
    end else if (period_end && pending_q) begin
      // Commit uses pre-edge shadow; a same-cycle write waits for next period.
      active_d  = shadow_q;
      pending_d = wr_hit;
    end else begin
      pending_d = pending_q | wr_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= PTR_A;
      pending_q  <= 1'b0;
      bad_addr_q <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        shadow_q[r] <= '0;
        active_q[r] <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      pending_q  <= pending_d;
      bad_addr_q <= bad_addr_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  assign en_out   = {active_q[ADDR_EN_OUT_HI], active_q[ADDR_EN_OUT_LO]};
  assign en_pwm   = {active_q[ADDR_EN_PWM_HI], active_q[ADDR_EN_PWM_LO]};
  assign duty     = active_q[ADDR_DUTY];
  assign pending  = pending_q;
  assign bad_addr = bad_addr_q;

endmodule
